// File: rtl/scoreboard_regfile.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_regfile
// Brief    : Two-read / one-write register file with a per-register busy
//            scoreboard. A reservation marks a register as having a write in
//            flight. A write clears the mark unless the same register is
//            re-reserved in the same cycle. pending_count tracks how many
//            registers are marked. Register 0 is hardwired to zero.
// Options  : define SCOREBOARD_REGFILE_BYPASS_EN to forward a same-cycle write
//            to a matching read port and hide that port's busy flag.
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_A,
    output logic                  busy_B,
    input  logic                  ctrl_reserveEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_reserveReg,
    output logic                  reserve_ack,
    output logic                  reserve_conflict,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int                NUM_REGS    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_COUNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic [ADDR_WIDTH:0]   r_count;

    logic w_writeHit;      // write to a real (nonzero) register this cycle
    logic w_writeSameResv; // that write targets the register being reserved
    logic w_accept;
    logic w_setBusy;       // accepted reservation of a nonzero register
    logic w_inc;           // a busy bit goes 0 -> 1 this edge
    logic w_dec;           // a busy bit goes 1 -> 0 this edge

    // Decode write / reservation interaction and the population-count delta.
    always_comb begin
        w_writeHit      = ctrl_writeEnable && (ctrl_writeReg != '0);
        w_writeSameResv = w_writeHit && (ctrl_writeReg == ctrl_reserveReg);
        // A busy register may be re-reserved only when its write lands now.
        w_accept        = ctrl_reserveEnable &&
                          ((ctrl_reserveReg == '0) || !r_busy[ctrl_reserveReg] || w_writeSameResv);
        w_setBusy       = w_accept && (ctrl_reserveReg != '0);
        w_inc           = w_setBusy && !r_busy[ctrl_reserveReg];
        // The reservation wins over a clearing write to the same register.
        w_dec           = w_writeHit && r_busy[ctrl_writeReg] &&
                          !(w_setBusy && (ctrl_reserveReg == ctrl_writeReg));
    end

    assign reserve_ack      = w_accept;
    assign reserve_conflict = ctrl_reserveEnable && !w_accept;
    assign pending_count    = r_count;

    // Register storage; register 0 is never written so it stays zero.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_writeHit) begin
            r_regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Busy scoreboard; the later set overrides the clear on a same-register hit.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_busy <= '0;
        end else begin
            if (w_writeHit) begin
                r_busy[ctrl_writeReg] <= 1'b0;
            end
            if (w_setBusy) begin
                r_busy[ctrl_reserveReg] <= 1'b1;
            end
        end
    end

    // Pending counter moves by at most one; a set and a clear on different
    // registers in the same cycle cancel out.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + c_COUNT_ONE;
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - c_COUNT_ONE;
        end
    end

    // Combinational read ports with optional same-cycle write forwarding.
    always_comb begin
        data_readRegA = (ctrl_readRegA == '0) ? '0 : r_regs[ctrl_readRegA];
        data_readRegB = (ctrl_readRegB == '0) ? '0 : r_regs[ctrl_readRegB];
        busy_A        = r_busy[ctrl_readRegA];
        busy_B        = r_busy[ctrl_readRegB];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        if (w_writeHit && (ctrl_writeReg == ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
            busy_A        = 1'b0;
        end
        if (w_writeHit && (ctrl_writeReg == ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
            busy_B        = 1'b0;
        end
`else
        // Reads see pre-edge contents; busy flags are the raw registered bits.
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_scoreboard_regfile
// Brief    : Self-checking bench for scoreboard_regfile: directed scenarios
//            followed by randomized traffic against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scoreboard_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock = 1'b0;
    logic          ctrl_reset_n = 1'b0;
    logic          ctrl_writeEnable = 1'b0;
    logic [AW-1:0] ctrl_writeReg = '0;
    logic [DW-1:0] data_writeReg = '0;
    logic [AW-1:0] ctrl_readRegA = '0;
    logic [AW-1:0] ctrl_readRegB = '0;
    logic [DW-1:0] data_readRegA;
    logic [DW-1:0] data_readRegB;
    logic          busy_A;
    logic          busy_B;
    logic          ctrl_reserveEnable = 1'b0;
    logic [AW-1:0] ctrl_reserveReg = '0;
    logic          reserve_ack;
    logic          reserve_conflict;
    logic [AW:0]   pending_count;

    always #5 clock = ~clock;

    scoreboard_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock              (clock),
        .ctrl_reset_n       (ctrl_reset_n),
        .ctrl_writeEnable   (ctrl_writeEnable),
        .ctrl_writeReg      (ctrl_writeReg),
        .data_writeReg      (data_writeReg),
        .ctrl_readRegA      (ctrl_readRegA),
        .ctrl_readRegB      (ctrl_readRegB),
        .data_readRegA      (data_readRegA),
        .data_readRegB      (data_readRegB),
        .busy_A             (busy_A),
        .busy_B             (busy_B),
        .ctrl_reserveEnable (ctrl_reserveEnable),
        .ctrl_reserveReg    (ctrl_reserveReg),
        .reserve_ack        (reserve_ack),
        .reserve_conflict   (reserve_conflict),
        .pending_count      (pending_count)
    );

    // Reference state: plain register contents and a set of pending registers.
    logic [DW-1:0] mRegs [NR];
    bit            mBusy [NR];

    int errCount   = 0;
    int checkCount = 0;

    logic          lastAck;
    logic          lastConflict;
    logic [DW-1:0] lastDataA;
    logic          lastBusyA;

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int popBusy();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(mBusy[i]);
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            mRegs[i] = '0;
            mBusy[i] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus, check the combinational view mid-cycle,
    // then advance the model across the edge and check the new count.
    task automatic doCycle(input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                           input logic re, input logic [AW-1:0] rr,
                           input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        logic [DW-1:0] expA, expB;
        logic          expBusyA, expBusyB, writeHit, accept;
        ctrl_writeEnable   = we;
        ctrl_writeReg      = wr;
        data_writeReg      = wd;
        ctrl_reserveEnable = re;
        ctrl_reserveReg    = rr;
        ctrl_readRegA      = ra;
        ctrl_readRegB      = rb;
        #3;
        writeHit = we && (wr != 0);
        expA     = (ra == 0) ? '0 : mRegs[ra];
        expB     = (rb == 0) ? '0 : mRegs[rb];
        expBusyA = mBusy[ra];
        expBusyB = mBusy[rb];
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        if (writeHit && wr == ra) begin expA = wd; expBusyA = 1'b0; end
        if (writeHit && wr == rb) begin expB = wd; expBusyB = 1'b0; end
`endif
        accept = re && ((rr == 0) || !mBusy[rr] || (writeHit && wr == rr));
        checkValue("readA",    64'(data_readRegA),    64'(expA));
        checkValue("readB",    64'(data_readRegB),    64'(expB));
        checkValue("busyA",    64'(busy_A),           64'(expBusyA));
        checkValue("busyB",    64'(busy_B),           64'(expBusyB));
        checkValue("ack",      64'(reserve_ack),      64'(accept));
        checkValue("conflict", 64'(reserve_conflict), 64'(re && !accept));
        checkValue("count",    64'(pending_count),    64'(popBusy()));
        lastAck      = reserve_ack;
        lastConflict = reserve_conflict;
        lastDataA    = data_readRegA;
        lastBusyA    = busy_A;
        @(posedge clock);
        #1;
        if (writeHit) begin
            mRegs[wr] = wd;
            mBusy[wr] = 1'b0;
        end
        if (accept && rr != 0) mBusy[rr] = 1'b1;
        checkValue("count_post", 64'(pending_count), 64'(popBusy()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          we, re;
        logic [AW-1:0] wr, rr, ra, rb;

        // Reset held across two edges, released mid-cycle.
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkValue("rst_count", 64'(pending_count), 64'd0);
        checkValue("rst_readA", 64'(data_readRegA), 64'd0);
        ctrl_reset_n = 1'b1;

        // Every address reads zero and idle after reset.
        for (int i = 0; i < NR; i++) begin
            doCycle(1'b0, '0, '0, 1'b0, '0, AW'(i), AW'(NR - 1 - i));
        end

        // Reserve, conflicting re-reserve, then the completing write.
        doCycle(1'b0, '0, '0, 1'b1, 5'd5, 5'd5, 5'd0);
        checkValue("r5_ack", 64'(lastAck), 64'd1);
        checkValue("r5_cnt", 64'(pending_count), 64'd1);
        doCycle(1'b0, '0, '0, 1'b1, 5'd5, 5'd5, 5'd0);
        checkValue("r5_conflict", 64'(lastConflict), 64'd1);
        checkValue("r5_cnt_hold", 64'(pending_count), 64'd1);
        doCycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd0);
        checkValue("w5_data", 64'(data_readRegA), 64'hDEADBEEF);
        checkValue("w5_busy", 64'(busy_A), 64'd0);
        checkValue("w5_cnt", 64'(pending_count), 64'd0);

        // Write and re-reserve of a busy register in the same cycle.
        doCycle(1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0);
        doCycle(1'b1, 5'd7, 32'h12, 1'b1, 5'd7, 5'd7, 5'd0);
        checkValue("r7_ack", 64'(lastAck), 64'd1);
        checkValue("r7_cnt", 64'(pending_count), 64'd1);
        doCycle(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd0);
        checkValue("r7_data", 64'(lastDataA), 64'h12);
        checkValue("r7_busy", 64'(lastBusyA), 64'd1);
        doCycle(1'b1, 5'd7, 32'h12, 1'b0, '0, 5'd0, 5'd0);

        // Register 0 ignores writes and reservations.
        doCycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        checkValue("r0_ack", 64'(lastAck), 64'd1);
        checkValue("r0_data", 64'(data_readRegA), 64'd0);
        checkValue("r0_cnt", 64'(pending_count), 64'd0);

        // Same-cycle write to a busy register that is being read.
        doCycle(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 5'd0, 5'd0);
        doCycle(1'b1, 5'd3, 32'hAB, 1'b0, '0, 5'd3, 5'd0);
`ifdef SCOREBOARD_REGFILE_BYPASS_EN
        checkValue("byp_data", 64'(lastDataA), 64'hAB);
        checkValue("byp_busy", 64'(lastBusyA), 64'd0);
`else
        checkValue("byp_data", 64'(lastDataA), 64'h1);
        checkValue("byp_busy", 64'(lastBusyA), 64'd1);
`endif

        // Asynchronous reset in the middle of a reservation sequence.
        doCycle(1'b0, '0, '0, 1'b1, 5'd1, 5'd1, 5'd2);
        doCycle(1'b0, '0, '0, 1'b1, 5'd2, 5'd1, 5'd2);
        ctrl_reserveEnable = 1'b1;
        ctrl_reserveReg    = 5'd3;
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        checkValue("arst_cnt",   64'(pending_count), 64'd0);
        checkValue("arst_busyA", 64'(busy_A),        64'd0);
        checkValue("arst_busyB", 64'(busy_B),        64'd0);
        checkValue("arst_readA", 64'(data_readRegA), 64'd0);
        modelReset();
        @(posedge clock);
        #1;
        checkValue("arst_hold", 64'(pending_count), 64'd0);
        ctrl_reset_n = 1'b1;
        // Operations presented in the release cycle land on the first edge.
        doCycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd4, 5'd9, 5'd4);
        doCycle(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd4);

        // Randomized traffic, biased toward a few registers to force collisions.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 7));
            rr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NR - 1)) : AW'($urandom_range(0, 7));
            ra = ($urandom_range(0, 1) == 0) ? wr : AW'($urandom_range(0, 7));
            rb = ($urandom_range(0, 1) == 0) ? rr : AW'($urandom_range(0, NR - 1));
            doCycle(we, wr, DW'($urandom), re, rr, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
